ccff_chain_programmer: RTL
==========================

# ccff_chain_programmer

- Drives the configuration-chain input `ccff_head` of a grid tile chain and observes its `ccff_tail` output.
- Accepts bitstream words over a valid/ready stream and serializes them LSB-first into the chain.
- Produces a clock-enable for the external gate on the chain's `prog_clk`, so the chain shifts only on programmed bits.
- Sits in the configuration controller, between the bitstream fetch logic and the first tile's `ccff_head`.

## Interface
Parameters:
- `CHAIN_LEN`, default 64: total flip-flops in the attached chain; must be ≥ 1.
- `WORD_W`, default 8: bitstream word width; must be ≥ 1.

Ports:
- `prog_clk` in 1: configuration clock.
- `pReset` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a programming pass; honoured only in IDLE.
- `abort` in 1: synchronous abort; returns to IDLE.
- `word_data` in WORD_W: bitstream word; bit 0 is shifted first.
- `word_valid` in 1: `word_data` is valid.
- `word_ready` out 1: the block accepts a word this cycle.
- `ccff_head` out 1: serial bit into the chain.
- `ccff_tail` in 1: serial bit out of the chain.
- `ccff_clk_en` out 1: enables the gated chain clock for the edge that ends this cycle.
- `busy` out 1: a pass is in progress.
- `done` out 1: one-cycle pulse when the pass completes.
- `bit_cnt` out $clog2(CHAIN_LEN+1): number of bits shifted so far in this pass.
- `rb_data` out WORD_W: readback word.
- `rb_valid` out 1: one-cycle readback strobe.

## Operation
States: IDLE, LOAD, SHIFT, DONE.

- **IDLE**
  - If `start`=1, clear `bit_cnt` and go to LOAD.
  - `start` in any other state is ignored.
- **LOAD**
  - `word_ready`=1.
  - On `word_valid`&`word_ready`, latch `word_data` into the shift register.
  - Set the segment length n = min(WORD_W, CHAIN_LEN−`bit_cnt`), then go to SHIFT.
- **SHIFT**
  - `ccff_clk_en`=1 and `ccff_head` = shift register bit 0.
  - Each cycle: shift the register right, increment `bit_cnt`, and decrement the segment counter.
  - After the n-th cycle, go to DONE if `bit_cnt` has reached CHAIN_LEN, otherwise go to LOAD.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- **Outputs by state**
  - `busy`=1 in LOAD, SHIFT and DONE.
  - `ccff_clk_en`=0 outside SHIFT.
  - `ccff_head` is held at 0 outside SHIFT.
- **Partial last word**
  - Only the low n bits are shifted; upper bits are discarded.
- **Chain ordering**
  - The first bit shifted ends at the tail flip-flop.
  - The last bit shifted ends at the head flip-flop.
- **abort**
  - Has priority over all transitions in any state.
  - Next cycle the block is in IDLE with `ccff_clk_en`=0 and `done`=0.
  - `bit_cnt` holds its value for diagnosis.
  - Any partial readback word is dropped.
- **Reset**
  - Forces IDLE immediately, including mid-SHIFT.
  - All outputs go to 0, and `bit_cnt`=0.
  - `ccff_clk_en` drops asynchronously, so no further chain edges occur.

## Timing
- `start` sampled at cycle 0 → LOAD in cycle 1.
- A handshake in LOAD cycle k → SHIFT in cycles k+1 … k+n.
- Minimum one LOAD bubble between segments; the chain does not shift during the bubble.
- Full pass with `word_valid` held high: CHAIN_LEN shift cycles + ceil(CHAIN_LEN/WORD_W) LOAD cycles + 2 (start→LOAD, DONE).
- `ccff_head` and `ccff_clk_en` are registered. Both are stable for the whole SHIFT cycle, and the chain samples `ccff_head` at the closing edge.
- `ccff_tail` is sampled at the same edge, before the chain shifts.

## Configuration
Macro: `CCFF_READBACK_EN`.

- **Defined**
  - Each SHIFT cycle captures `ccff_tail` into a readback register, LSB-first.
  - This captures the chain's previous contents.
  - After WORD_W captured bits, or at the final shift of the pass, `rb_data` is presented with `rb_valid`=1 for one cycle.
  - Uncaptured high bits of `rb_data` are 0.
  - There is no backpressure.
- **Undefined**
  - `rb_data`=0 and `rb_valid`=0 constantly; the capture logic is absent.

## Structure
- **Package `ccff_prog_pkg`**
  - State enum `ccff_prog_state_e` {IDLE, LOAD, SHIFT, DONE}.
  - Width helper constants for `bit_cnt` and the segment counter.
- **Sub-module `ccff_rb_capture`**
  - Readback shift register, bit counter and strobe.
  - Instantiated only under `CCFF_READBACK_EN`.

## Test plan
Bench: CHAIN_LEN=20, WORD_W=8, with a 20-bit shift-register model of the chain clocked by `prog_clk`&`ccff_clk_en`.

1. Full pass
   - Stimulus: words 0xA5, 0x3C, 0x0F, `word_valid` held high, `start` at cycle 0.
   - Response: shift cycles 2–9, 11–18, 20–23; `done` at cycle 24; chain model = {0xF, 0x3C, 0xA5} (first bit at the tail); `bit_cnt`=20.
2. Stall
   - Stimulus: `word_valid` low for 5 cycles in the second LOAD.
   - Response: `ccff_clk_en`=0 throughout the stall; final chain contents identical to scenario 1.
3. Abort
   - Stimulus: `abort` in the 3rd cycle of the 2nd segment.
   - Response: IDLE next cycle; `bit_cnt`=11; no further `ccff_clk_en`; no `done`.
4. Reset mid-SHIFT
   - Stimulus: `pReset` low during SHIFT.
   - Response: `ccff_clk_en`, `busy`, `word_ready` and `ccff_head` at 0 immediately; IDLE after release.
5. Readback (`CCFF_READBACK_EN`)
   - Stimulus: chain preloaded with scenario-1 data, second pass with words 0xFF, 0xFF, 0xFF.
   - Response: `rb_data` strobes 0xA5, 0x3C, 0x0F; chain ends at all ones.
6. `start` while busy
   - Stimulus: pulse `start` during SHIFT.
   - Response: ignored; pass completes normally with exactly 20 shift cycles.

Source files
------------

// File: rtl/ccff_prog_pkg.sv
// rtl/ccff_prog_pkg.sv - shared state encoding and width helpers for the configuration chain programmer
package ccff_prog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ccff_prog_state_e;

    // Bits needed to hold a count from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ccff_rb_capture.sv
// rtl/ccff_rb_capture.sv - captures ccff_tail LSB-first and strobes completed readback words
module ccff_rb_capture
    import ccff_prog_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              last,
    input  logic              clear,
    input  logic              tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int IDX_W = (WORD_W < 2) ? 1 : $clog2(WORD_W);

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_nxt;
    logic [IDX_W-1:0]  idx;
    logic              word_full;

    assign word_full = (idx == IDX_W'(WORD_W - 1));

    // Place the sampled tail bit at the next free position of the accumulator.
    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < WORD_W; i++) begin
            if (idx == IDX_W'(i)) begin
                acc_nxt[i] = tail;
            end
        end
    end

    // Accumulate bits; emit a word when full or at the final shift, drop partial words on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            idx      <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (clear) begin
                acc <= '0;
                idx <= '0;
            end else if (capture) begin
                if (word_full || last) begin
                    rb_data  <= acc_nxt;
                    rb_valid <= 1'b1;
                    acc      <= '0;
                    idx      <= '0;
                end else begin
                    acc <= acc_nxt;
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ccff_chain_programmer.sv
// rtl/ccff_chain_programmer.sv - serializes bitstream words into a ccff chain; readback under CCFF_READBACK_EN
module ccff_chain_programmer
    import ccff_prog_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic                           prog_clk,
    input  logic                           pReset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [WORD_W-1:0]              word_data,
    input  logic                           word_valid,
    output logic                           word_ready,
    output logic                           ccff_head,
    input  logic                           ccff_tail,
    output logic                           ccff_clk_en,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt,
    output logic [WORD_W-1:0]              rb_data,
    output logic                           rb_valid
);

    localparam int CNT_W = cnt_width(CHAIN_LEN);
    localparam int SEG_W = cnt_width(WORD_W);

    ccff_prog_state_e  state;
    ccff_prog_state_e  state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [SEG_W-1:0]  seg_cnt;
    logic [SEG_W-1:0]  seg_len;
    logic              accept;
    logic              seg_last;
    logic              pass_last;
    logic              head_nxt;

    // An abort in LOAD must not look like a consumed word to the source.
    assign word_ready = (state == LOAD) && !abort;
    assign accept     = word_valid && word_ready;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign seg_last   = (seg_cnt == SEG_W'(1));
    assign pass_last  = (bit_cnt == CNT_W'(CHAIN_LEN - 1));

    // Segment length: a full word, or whatever remains of the chain for the last word.
    always_comb begin
        seg_len = SEG_W'(WORD_W);
        if (int'(bit_cnt) + WORD_W > CHAIN_LEN) begin
            seg_len = SEG_W'(CHAIN_LEN - int'(bit_cnt));
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (seg_last) state_nxt = pass_last ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // Bit presented to the chain next cycle: first bit of a fresh word, or the next queued bit.
    always_comb begin
        head_nxt = 1'b0;
        if (state == LOAD) begin
            head_nxt = word_data[0];
        end else if (state == SHIFT) begin
            head_nxt = shreg[0];
        end
    end

    // Sequencer state, counters and registered chain drive.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state       <= IDLE;
            shreg       <= '0;
            seg_cnt     <= '0;
            bit_cnt     <= '0;
            ccff_head   <= 1'b0;
            ccff_clk_en <= 1'b0;
        end else begin
            state       <= state_nxt;
            ccff_clk_en <= (state_nxt == SHIFT);
            ccff_head   <= (state_nxt == SHIFT) && head_nxt;
            if ((state == IDLE) && start && !abort) begin
                bit_cnt <= '0;
            end
            if (accept) begin
                shreg   <= word_data >> 1;
                seg_cnt <= seg_len;
            end
            // The chain edge closing a SHIFT cycle happens even when aborting, so it is counted.
            if (state == SHIFT) begin
                shreg   <= shreg >> 1;
                seg_cnt <= seg_cnt - SEG_W'(1);
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

`ifdef CCFF_READBACK_EN
    ccff_rb_capture #(
        .WORD_W (WORD_W)
    ) u_rb_capture (
        .clk      (prog_clk),
        .rst_n    (pReset),
        .capture  (state == SHIFT),
        .last     (pass_last),
        .clear    (abort),
        .tail     (ccff_tail),
        .rb_data  (rb_data),
        .rb_valid (rb_valid)
    );
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign rb_data     = '0;
    assign rb_valid    = 1'b0;
`endif

endmodule
